// File: rtl/flt_job_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : flt_job_sequencer_if
// Purpose  : Job/result streams, core control and data-memory port bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface flt_job_sequencer_if;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_operand;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_value;
    logic        res_timeout;
    logic [15:0] job_count;
    logic        core_reset;
    logic        core_done;
    logic        mem_grant_core;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    // master: the sequencer; slave: producer, consumer, core and memory side
    modport master (
        input  job_valid, job_operand, res_ready, core_done, mem_rdata,
        output job_ready, res_valid, res_value, res_timeout, job_count,
               core_reset, mem_grant_core, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output job_valid, job_operand, res_ready, core_done, mem_rdata,
        input  job_ready, res_valid, res_value, res_timeout, job_count,
               core_reset, mem_grant_core, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/flt_job_sequencer.sv
//------------------------------------------------------------------------------
// Module   : flt_job_sequencer
// Purpose  : Loads an int operand into the core, runs it, unloads the float.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module flt_job_sequencer #(
    parameter int unsigned OP_HI_ADDR  = 128,
    parameter int unsigned OP_LO_ADDR  = 129,
    parameter int unsigned RES_HI_ADDR = 131,
    parameter int unsigned RES_LO_ADDR = 132,
    parameter int unsigned MIN_RUN     = 4,
    parameter int unsigned TIMEOUT     = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    flt_job_sequencer_if.master  bus
);

    localparam logic [7:0]  c_op_hi   = 8'(OP_HI_ADDR);
    localparam logic [7:0]  c_op_lo   = 8'(OP_LO_ADDR);
    localparam logic [7:0]  c_res_hi  = 8'(RES_HI_ADDR);
    localparam logic [7:0]  c_res_lo  = 8'(RES_LO_ADDR);
    localparam logic [11:0] c_min_run = 12'(MIN_RUN);
    localparam logic [11:0] c_timeout = 12'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_HI  = 3'd1,
        S_WR_LO  = 3'd2,
        S_WR_SGN = 3'd3,
        S_RUN    = 3'd4,
        S_RD_HI  = 3'd5,
        S_RD_LO  = 3'd6,
        S_OUT    = 3'd7
    } state_t;

    state_t      r_state;
    logic        r_sgn;
    logic [7:0]  r_op_lo;
    logic [6:0]  r_hi;
    logic [11:0] r_run_cnt;
    logic        r_core_reset;
    logic        r_grant;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_res_valid;
    logic [15:0] r_res_value;
    logic        r_res_timeout;
    logic [15:0] r_job_count;

    // Outputs are registered one state ahead so they are valid for the
    // whole duration of the state that owns them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_sgn         <= 1'b0;
            r_op_lo       <= 8'd0;
            r_hi          <= 7'd0;
            r_run_cnt     <= 12'd0;
            r_core_reset  <= 1'b1;
            r_grant       <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 8'd0;
            r_mem_wdata   <= 8'd0;
            r_res_valid   <= 1'b0;
            r_res_value   <= 16'd0;
            r_res_timeout <= 1'b0;
            r_job_count   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        r_sgn       <= bus.job_operand[15];
                        r_op_lo     <= bus.job_operand[7:0];
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= c_op_hi;
                        r_mem_wdata <= bus.job_operand[15:8];
                        r_state     <= S_WR_HI;
                    end
                end
                S_WR_HI: begin
                    r_mem_addr  <= c_op_lo;
                    r_mem_wdata <= r_op_lo;
                    r_state     <= S_WR_LO;
                end
                S_WR_LO: begin
                    r_mem_addr  <= c_res_hi;
                    r_mem_wdata <= {r_sgn, 7'd0};
                    r_state     <= S_WR_SGN;
                end
                S_WR_SGN: begin
                    r_mem_we     <= 1'b0;
                    r_core_reset <= 1'b0;
                    r_grant      <= 1'b1;
                    r_run_cnt    <= 12'd0;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    // A done left over from the previous job is masked for MIN_RUN cycles
                    if (bus.core_done && (r_run_cnt >= c_min_run)) begin
                        r_core_reset <= 1'b1;
                        r_grant      <= 1'b0;
                        r_mem_addr   <= c_res_hi;
                        r_state      <= S_RD_HI;
                    end else if (r_run_cnt == c_timeout) begin
                        r_core_reset  <= 1'b1;
                        r_grant       <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_res_timeout <= 1'b1;
                        r_res_value   <= 16'd0;
                        r_state       <= S_OUT;
                    end else begin
                        r_run_cnt <= r_run_cnt + 12'd1;
                    end
                end
                S_RD_HI: begin
                    r_hi       <= bus.mem_rdata[6:0];
                    r_mem_addr <= c_res_lo;
                    r_state    <= S_RD_LO;
                end
                S_RD_LO: begin
                    r_res_value   <= {r_sgn, r_hi, bus.mem_rdata};
                    r_res_timeout <= 1'b0;
                    r_res_valid   <= 1'b1;
                    r_state       <= S_OUT;
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_job_count <= r_job_count + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.job_ready      = (r_state == S_IDLE);
    assign bus.res_valid      = r_res_valid;
    assign bus.res_value      = r_res_value;
    assign bus.res_timeout    = r_res_timeout;
    assign bus.job_count      = r_job_count;
    assign bus.core_reset     = r_core_reset;
    assign bus.mem_grant_core = r_grant;
    assign bus.mem_we         = r_mem_we;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_flt_job_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_flt_job_sequencer
// Purpose  : Directed bench with a behavioural core and data memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_flt_job_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    flt_job_sequencer_if bus ();

    flt_job_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem [256];
    logic [15:0] core_word = 16'd0;
    int          core_delay = 4;
    logic        stale = 1'b0;
    logic        never = 1'b0;
    int          core_cnt = 0;

    int          lat;
    int          run_len;
    logic [7:0]  sgn_byte;
    logic        saw132;
    logic [15:0] held;

    // Core counts its own run cycles, publishes its result and raises done
    always @(posedge clk) begin
        if (bus.core_reset) core_cnt <= 0;
        else                core_cnt <= core_cnt + 1;
    end

    always @(posedge clk) begin
        if (!bus.core_reset && !never && core_cnt == core_delay) begin
            mem[131] <= core_word[15:8];
            mem[132] <= core_word[7:0];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.core_done = stale | (!bus.core_reset && !never && core_cnt >= core_delay);
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) check("we_while_granted", {31'd0, bus.mem_grant_core}, 32'd0);
    end

    // Offer one job, wait (bounded) for res_valid; lat = cycle index from accept
    task automatic do_job(input logic [15:0] op, input logic [15:0] word, input int delay);
        core_word = word;
        core_delay = delay;
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_operand = op;
        check("ready_before_job", {31'd0, bus.job_ready}, 32'd1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        lat = 1;
        run_len = 0;
        sgn_byte = 8'hxx;
        saw132 = 1'b0;
        while (!bus.res_valid && lat < 5000) begin
            if (!bus.core_reset) begin
                if (run_len == 0) sgn_byte = mem[131];
                run_len++;
            end
            if (bus.mem_addr == 8'd132) saw132 = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("res_valid_seen", {31'd0, bus.res_valid}, 32'd1);
        check("ready_low_in_out", {31'd0, bus.job_ready}, 32'd0);
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_operand = 16'd0;
        bus.res_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_job_ready", {31'd0, bus.job_ready}, 32'd1);
        check("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
        check("rst_grant", {31'd0, bus.mem_grant_core}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_addr", {24'd0, bus.mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_value", {16'd0, bus.res_value}, 32'd0);
        check("rst_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
        check("rst_job_count", {16'd0, bus.job_count}, 32'd0);
        reset = 1'b0;

        // Job 1, done after 6 run cycles
        do_job(16'd1, 16'h3C00, 6);
        check("j1_latency", lat, 32'd13);
        check("j1_run_len", run_len, 32'd7);
        check("j1_mem128", {24'd0, mem[128]}, 32'h00);
        check("j1_mem129", {24'd0, mem[129]}, 32'h01);
        check("j1_mem131", {24'd0, sgn_byte}, 32'h00);
        check("j1_value", {16'd0, bus.res_value}, 32'h3C00);
        check("j1_timeout", {31'd0, bus.res_timeout}, 32'd0);
        @(negedge clk);
        check("j1_count", {16'd0, bus.job_count}, 32'd1);
        check("j1_idle", {31'd0, bus.job_ready}, 32'd1);

        // Back-to-back jobs from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_job(16'd12, 16'h4A00, 5);
        check("b2b_12", {16'd0, bus.res_value}, 32'h4A00);
        check("b2b_12_lat", lat, 32'd12);
        do_job(16'd32767, 16'h7800, 8);
        check("b2b_32767", {16'd0, bus.res_value}, 32'h7800);
        check("b2b_32767_mem128", {24'd0, mem[128]}, 32'h7F);
        check("b2b_32767_mem129", {24'd0, mem[129]}, 32'hFF);
        do_job(16'd48, 16'h5200, 4);
        check("b2b_48", {16'd0, bus.res_value}, 32'h5200);
        @(negedge clk);
        check("b2b_count", {16'd0, bus.job_count}, 32'd3);

        // Stale done held high: must still spend exactly MIN_RUN+1 cycles in RUN
        stale = 1'b1;
        do_job(16'hFFFE, 16'h4000, 4);
        stale = 1'b0;
        check("stale_run_len", run_len, 32'd5);
        check("stale_latency", lat, 32'd11);
        check("stale_sgn_byte", {24'd0, sgn_byte}, 32'h80);
        check("stale_mem128", {24'd0, mem[128]}, 32'hFF);
        check("stale_value", {16'd0, bus.res_value}, 32'hC000);

        // Timeout: core never finishes
        never = 1'b1;
        do_job(16'd5, 16'h1234, 4);
        check("to_latency", lat, 32'd4100);
        check("to_value", {16'd0, bus.res_value}, 32'h0000);
        check("to_flag", {31'd0, bus.res_timeout}, 32'd1);
        check("to_no_read", {31'd0, saw132}, 32'd0);
        never = 1'b0;
        @(negedge clk);
        check("to_count", {16'd0, bus.job_count}, 32'd5);

        // Backpressure
        bus.res_ready = 1'b0;
        do_job(16'd48, 16'h5200, 4);
        held = bus.res_value;
        check("bp_value", {16'd0, held}, 32'h5200);
        check("bp_timeout_cleared", {31'd0, bus.res_timeout}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, bus.res_valid}, 32'd1);
            check("bp_hold_value", {16'd0, bus.res_value}, 32'h5200);
            check("bp_hold_ready", {31'd0, bus.job_ready}, 32'd0);
            check("bp_hold_count", {16'd0, bus.job_count}, 32'd5);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", {31'd0, bus.res_valid}, 32'd0);
        check("bp_released_idle", {31'd0, bus.job_ready}, 32'd1);
        check("bp_count", {16'd0, bus.job_count}, 32'd6);
        @(negedge clk);
        check("bp_single_count", {16'd0, bus.job_count}, 32'd6);

        // Asynchronous reset mid-RUN
        core_delay = 20;
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_operand = 16'd7;
        @(negedge clk);
        bus.job_valid = 1'b0;
        for (int i = 0; i < 20 && bus.core_reset; i++) @(negedge clk);
        check("mid_in_run", {31'd0, bus.mem_grant_core}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_core_reset", {31'd0, bus.core_reset}, 32'd1);
        check("mid_grant", {31'd0, bus.mem_grant_core}, 32'd0);
        check("mid_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("mid_job_ready", {31'd0, bus.job_ready}, 32'd1);
        check("mid_count", {16'd0, bus.job_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_job(16'd12, 16'h4A00, 6);
        check("post_rst_value", {16'd0, bus.res_value}, 32'h4A00);
        check("post_rst_latency", lat, 32'd13);
        @(negedge clk);
        check("post_rst_count", {16'd0, bus.job_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
